// File: rtl/clk_div_cfg_ctrl_if.sv
// ---------------------------------------------------------------------------
// clk_div_cfg_ctrl_if
//   Bundles the ratio-change controller's request/grant and divider-control
//   signals. Clock and reset stay outside as plain ports.
//
//   req[1:0]    ratio-change request per requester (level, held until gnt)
//   ratio0/1    ratio requested by requester 0 / 1
//   div_phase   divider's internal divided-clock register
//   gnt[1:0]    one-hot, one-cycle grant pulse
//   div_ratio   ratio driven to the divider
//   clk_en      divider enable
//   busy        controller is sequencing (not idle)
//   locked      current ratio is applied and settled
//   err         sticky low-phase wait timeout flag
//
//   master : requesters / divider side (drives requests and phase)
//   slave  : the controller
// ---------------------------------------------------------------------------
interface clk_div_cfg_ctrl_if;
  logic [1:0] req;
  logic [7:0] ratio0;
  logic [7:0] ratio1;
  logic       div_phase;
  logic [1:0] gnt;
  logic [7:0] div_ratio;
  logic       clk_en;
  logic       busy;
  logic       locked;
  logic       err;

  modport master (
    output req, ratio0, ratio1, div_phase,
    input  gnt, div_ratio, clk_en, busy, locked, err
  );

  modport slave (
    input  req, ratio0, ratio1, div_phase,
    output gnt, div_ratio, clk_en, busy, locked, err
  );
endinterface

// File: rtl/clk_div_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_cfg_ctrl
//   Ratio-change controller for the system clock divider. Two requesters are
//   arbitrated round-robin; each accepted change is sequenced as: wait for
//   the divided clock's low phase, drop the divider enable, load the new
//   ratio, re-enable and let the divider settle.
//
//   Ports:
//     i_ref_clk  reference clock (same clock as the divider)
//     i_rst_n    asynchronous, active-low reset
//     bus        clk_div_cfg_ctrl_if.slave (requests, grant, divider control)
//
//   Optional feature, macro CLK_DIV_CTRL_TIMEOUT_EN:
//     defined   -> WAIT_LOW gives up after WAIT_TO cycles, proceeds to GATE
//                  and sets the sticky err flag.
//     undefined -> WAIT_LOW waits indefinitely; err is tied low.
// ---------------------------------------------------------------------------
module clk_div_cfg_ctrl #(
  parameter logic [7:0] RST_RATIO  = 8'd2,
  parameter int         HOLD_CYC   = 4,
  parameter int         SETTLE_CYC = 16
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
  ,
  parameter int         WAIT_TO    = 255
`endif
) (
  input logic               i_ref_clk,
  input logic               i_rst_n,
  clk_div_cfg_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CHECK    = 3'd1;
  localparam logic [2:0] S_WAIT_LOW = 3'd2;
  localparam logic [2:0] S_GATE     = 3'd3;
  localparam logic [2:0] S_LOAD     = 3'd4;
  localparam logic [2:0] S_SETTLE   = 3'd5;

  // One shared counter serves GATE, SETTLE and (optionally) WAIT_LOW.
  localparam int BASE_MAX = (HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
  localparam int CNT_MAX  = (WAIT_TO > BASE_MAX) ? WAIT_TO : BASE_MAX;
`else
  localparam int CNT_MAX  = BASE_MAX;
`endif
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             ptr;
  logic             winner;
  logic [7:0]       pend_ratio;
  logic [1:0]       gnt_q;
  logic [7:0]       ratio_q;
  logic             clk_en_q;
  logic             locked_q;

  // The pointer holds priority on a tie; otherwise whoever is requesting wins.
  // NOTE: assign a default first in always_comb so no path leaves the
  // variable unassigned, which would infer a latch.
  always_comb begin
    winner = ptr;
    if (!bus.req[ptr]) winner = ~ptr;
  end

`ifdef CLK_DIV_CTRL_TIMEOUT_EN
  logic err_q;
`endif

  // NOTE: every register, including the pend_ratio data holder, is reset so
  // an asynchronous reset mid-sequence discards any pending change cleanly.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_SETTLE;
      cnt        <= '0;
      ptr        <= 1'b0;
      pend_ratio <= RST_RATIO;
      gnt_q      <= '0;
      ratio_q    <= RST_RATIO;
      clk_en_q   <= 1'b0;
      locked_q   <= 1'b0;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples
      // the pre-edge values, independent of statement order.
      gnt_q <= '0;
      case (state)
        S_IDLE: begin
          if (|bus.req) begin
            pend_ratio <= winner ? bus.ratio1 : bus.ratio0;
            gnt_q      <= winner ? 2'b10 : 2'b01;
            ptr        <= ~winner;
            state      <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (pend_ratio == ratio_q) begin
            state <= S_IDLE;
          end else begin
            locked_q <= 1'b0;
            cnt      <= '0;
            // A bypassed divider (ratio 0/1) has no divided phase to wait on.
            state    <= (ratio_q < 8'd2) ? S_GATE : S_WAIT_LOW;
          end
        end
        S_WAIT_LOW: begin
          if (!bus.div_phase) begin
            state <= S_GATE;
            cnt   <= '0;
          end
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
          else if (cnt == CNT_W'(WAIT_TO - 1)) begin
            state <= S_GATE;
            cnt   <= '0;
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        S_GATE: begin
          clk_en_q <= 1'b0;
          if (cnt == CNT_W'(HOLD_CYC - 1)) begin
            // Ratio updates on the GATE->LOAD edge, with the enable already low.
            ratio_q <= pend_ratio;
            state   <= S_LOAD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LOAD: begin
          clk_en_q <= (ratio_q >= 8'd2);
          cnt      <= '0;
          state    <= S_SETTLE;
        end
        S_SETTLE: begin
          clk_en_q <= (ratio_q >= 8'd2);
          if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
            locked_q <= 1'b1;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_SETTLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.div_ratio = ratio_q;
  assign bus.clk_en    = clk_en_q;
  assign bus.busy      = (state != S_IDLE);
  assign bus.locked    = locked_q;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_div_cfg_ctrl
//   Directed bench for clk_div_cfg_ctrl with default parameters
//   (RST_RATIO=2, HOLD_CYC=4, SETTLE_CYC=16). Edge numbers in comments count
//   rising edges after the request is presented (E1 = first edge).
//   Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_clk_div_cfg_ctrl;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  clk_div_cfg_ctrl_if bus ();

  clk_div_cfg_ctrl dut (
    .i_ref_clk (clk),
    .i_rst_n   (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    rst_n        = 1'b1;
    bus.req      = 2'b00;
    bus.ratio0   = 8'd0;
    bus.ratio1   = 8'd0;
    bus.div_phase = 1'b0;

    // ---- reset values ----
    #1 rst_n = 1'b0;
    #1;
    check("rst_gnt",    bus.gnt,       2'b00);
    check("rst_ratio",  bus.div_ratio, 8'd2);
    check("rst_clk_en", bus.clk_en,    1'b0);
    check("rst_busy",   bus.busy,      1'b1);
    check("rst_locked", bus.locked,    1'b0);
    check("rst_err",    bus.err,       1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ---- 1: reset release, settle ----
    step(1);
    check("t1_clk_en_c1", bus.clk_en, 1'b1);
    check("t1_locked_c1", bus.locked, 1'b0);
    step(14);
    check("t1_locked_c15", bus.locked, 1'b0);
    step(1);
    check("t1_locked_c16", bus.locked, 1'b1);
    check("t1_busy_c16",   bus.busy,   1'b0);
    check("t1_ratio",      bus.div_ratio, 8'd2);

    // ---- 2: requester 0 -> ratio 8, phase low ----
    bus.ratio0 = 8'd8;
    bus.req    = 2'b01;
    step(1);                                    // E1
    check("t2_gnt_e1",    bus.gnt,    2'b01);
    check("t2_locked_e1", bus.locked, 1'b1);
    bus.req = 2'b00;
    step(1);                                    // E2
    check("t2_gnt_e2",    bus.gnt,    2'b00);
    check("t2_locked_e2", bus.locked, 1'b0);
    step(1);                                    // E3
    check("t2_clk_en_e3", bus.clk_en, 1'b1);
    step(1);                                    // E4
    check("t2_clk_en_e4", bus.clk_en, 1'b0);
    step(2);                                    // E6
    check("t2_ratio_e6",  bus.div_ratio, 8'd2);
    step(1);                                    // E7
    check("t2_ratio_e7",  bus.div_ratio, 8'd8);
    check("t2_clk_en_e7", bus.clk_en, 1'b0);
    step(1);                                    // E8
    check("t2_clk_en_e8", bus.clk_en, 1'b1);
    step(15);                                   // E23
    check("t2_locked_e23", bus.locked, 1'b0);
    step(1);                                    // E24
    check("t2_locked_e24", bus.locked, 1'b1);
    check("t2_busy_e24",   bus.busy,   1'b0);

    // ---- 4: requester 1 asks for the current ratio (pointer now at 1) ----
    bus.ratio1 = 8'd8;
    bus.req    = 2'b10;
    step(1);
    check("t4_gnt",    bus.gnt,    2'b10);
    check("t4_clk_en", bus.clk_en, 1'b1);
    bus.req = 2'b00;
    step(1);
    check("t4_busy",   bus.busy,   1'b0);
    check("t4_locked", bus.locked, 1'b1);
    check("t4_clk_en2", bus.clk_en, 1'b1);
    check("t4_ratio",  bus.div_ratio, 8'd8);

    // ---- 3: both requesters held, grants alternate (pointer now at 0) ----
    bus.ratio0 = 8'd4;
    bus.ratio1 = 8'd6;
    bus.req    = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step(1);                                  // E1
      check($sformatf("t3_gnt_%0d", i), bus.gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      step(1);                                  // E2: requests ignored while busy
      check($sformatf("t3_nogrant_%0d", i), bus.gnt, 2'b00);
      step(5);                                  // E7
      check($sformatf("t3_ratio_%0d", i), bus.div_ratio, (i % 2 == 0) ? 8'd4 : 8'd6);
      step(17);                                 // E24
      check($sformatf("t3_locked_%0d", i), bus.locked, 1'b1);
    end
    bus.req = 2'b00;

    // ---- 5a: ratio 1 (bypass) from ratio 4 (pointer now at 1) ----
    bus.ratio1 = 8'd1;
    bus.req    = 2'b10;
    step(1);
    check("t5a_gnt", bus.gnt, 2'b10);
    bus.req = 2'b00;
    step(6);                                    // E7
    check("t5a_ratio_e7",  bus.div_ratio, 8'd1);
    step(1);                                    // E8
    check("t5a_clk_en_e8", bus.clk_en, 1'b0);
    step(16);                                   // E24
    check("t5a_locked",    bus.locked, 1'b1);
    check("t5a_clk_en_e24", bus.clk_en, 1'b0);

    // ---- 5b: ratio 3 from bypass; phase held high, WAIT_LOW skipped ----
    bus.div_phase = 1'b1;
    bus.ratio0    = 8'd3;
    bus.req       = 2'b01;
    step(1);                                    // E1
    check("t5b_gnt", bus.gnt, 2'b01);
    bus.req = 2'b00;
    step(4);                                    // E5
    check("t5b_ratio_e5",  bus.div_ratio, 8'd1);
    step(1);                                    // E6
    check("t5b_ratio_e6",  bus.div_ratio, 8'd3);
    check("t5b_clk_en_e6", bus.clk_en, 1'b0);
    step(1);                                    // E7
    check("t5b_clk_en_e7", bus.clk_en, 1'b1);
    step(16);                                   // E23
    check("t5b_locked_e23", bus.locked, 1'b1);
    bus.div_phase = 1'b0;

    // ---- 6a: reset asserted during GATE ----
    bus.ratio1 = 8'd5;
    bus.req    = 2'b10;
    step(1);
    check("t6a_gnt", bus.gnt, 2'b10);
    step(3);                                    // E4: in GATE, enable low
    check("t6a_clk_en_gate", bus.clk_en, 1'b0);
    step(1);                                    // E5
    bus.req = 2'b00;
    rst_n   = 1'b0;
    #1;
    check("t6a_rst_gnt",    bus.gnt,       2'b00);
    check("t6a_rst_ratio",  bus.div_ratio, 8'd2);
    check("t6a_rst_clk_en", bus.clk_en,    1'b0);
    check("t6a_rst_busy",   bus.busy,      1'b1);
    check("t6a_rst_locked", bus.locked,    1'b0);
    check("t6a_rst_err",    bus.err,       1'b0);
    step(1);
    rst_n = 1'b1;
    step(16);
    check("t6a_relock",    bus.locked,    1'b1);
    check("t6a_ratio_kept", bus.div_ratio, 8'd2);
    // Pointer is back at requester 0 after reset.
    bus.ratio0 = 8'd2;
    bus.ratio1 = 8'd7;
    bus.req    = 2'b11;
    step(1);
    check("t6a_ptr_rst", bus.gnt, 2'b01);
    bus.req = 2'b00;
    step(1);
    check("t6a_same_idle", bus.busy, 1'b0);

    // ---- 6b: divided phase stuck high ----
    bus.div_phase = 1'b1;
    bus.ratio1    = 8'd9;
    bus.req       = 2'b10;
    step(1);
    check("t6b_gnt", bus.gnt, 2'b10);
    bus.req = 2'b00;
    step(300);
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
    check("t6b_err",    bus.err,       1'b1);
    check("t6b_ratio",  bus.div_ratio, 8'd9);
    check("t6b_locked", bus.locked,    1'b1);
`else
    check("t6b_busy",   bus.busy,      1'b1);
    check("t6b_ratio",  bus.div_ratio, 8'd2);
    check("t6b_err",    bus.err,       1'b0);
    check("t6b_clk_en", bus.clk_en,    1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
